// File: rtl/decode_pkg.sv
// Shared decode/issue types: instruction classes, field positions,
// decoded slot record and issue state.
package decode_pkg;

    typedef enum logic [2:0] {
        OP_ALUR   = 3'b000,
        OP_ALUI   = 3'b001,
        OP_LOAD   = 3'b010,
        OP_STORE  = 3'b011,
        OP_BRANCH = 3'b100,
        OP_JUMP   = 3'b101,
        OP_RSVD   = 3'b110,
        OP_NOP    = 3'b111
    } op_class_t;

    localparam logic [31:0] NOP_WORD = {3'b111, 29'b0};

    localparam int CLS_LO = 29;
    localparam int RD_LO  = 24;
    localparam int RS_LO  = 19;
    localparam int RT_LO  = 14;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rd_we;
        logic       rs_rd;
        logic       rt_rd;
        logic       is_load;
        logic       is_branch;
    } dec_slot_t;

    typedef enum logic {
        FULL   = 1'b0,
        SECOND = 1'b1
    } state_t;

    function automatic logic reads_reg(dec_slot_t s, logic [4:0] r);
        return s.valid && ((s.rs_rd && s.rs == r) || (s.rt_rd && s.rt == r));
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch-to-decode bundle bus and the decoded issue outputs.
// master = fetch/consumer side, slave = decode_issue.
interface decode_issue_if;
    logic [63:0] bundle_in;
    logic [31:0] pc_in;
    logic        flush;
    logic        decode_stall;
    logic        interlock;
    logic [1:0]  dec_valid;
    logic [63:0] dec_inst;
    logic [31:0] dec_pc;
    logic [9:0]  dec_rd;
    logic [9:0]  dec_rs;
    logic [9:0]  dec_rt;
    logic [1:0]  dec_we;
    logic [1:0]  dec_is_load;
    logic [1:0]  dec_is_branch;

    modport master (
        output bundle_in, pc_in, flush, decode_stall,
        input  interlock, dec_valid, dec_inst, dec_pc,
        input  dec_rd, dec_rs, dec_rt, dec_we, dec_is_load, dec_is_branch
    );

    modport slave (
        input  bundle_in, pc_in, flush, decode_stall,
        output interlock, dec_valid, dec_inst, dec_pc,
        output dec_rd, dec_rs, dec_rt, dec_we, dec_is_load, dec_is_branch
    );
endinterface

// File: rtl/decode_issue_slot_decoder.sv
// Combinational decode of one 32-bit instruction word into a dec_slot_t.
module slot_decoder
    import decode_pkg::*;
(
    input  logic [31:0] word_i,
    output dec_slot_t   slot_o
);
    op_class_t cls;
    logic      wr;
    logic      unused_imm;

    assign cls        = op_class_t'(word_i[CLS_LO +: 3]);
    assign unused_imm = ^word_i[RT_LO-1:0];

    always_comb begin
        slot_o       = '0;
        wr           = 1'b0;
        slot_o.valid = (cls != OP_NOP);
        slot_o.rd    = word_i[RD_LO +: 5];
        slot_o.rs    = word_i[RS_LO +: 5];
        slot_o.rt    = word_i[RT_LO +: 5];
        unique case (cls)
            OP_ALUR:   begin slot_o.rs_rd = 1'b1; slot_o.rt_rd = 1'b1; wr = 1'b1; end
            OP_ALUI:   begin slot_o.rs_rd = 1'b1; wr = 1'b1; end
            OP_LOAD:   begin slot_o.rs_rd = 1'b1; wr = 1'b1; slot_o.is_load = 1'b1; end
            OP_STORE:  begin slot_o.rs_rd = 1'b1; slot_o.rt_rd = 1'b1; end
            OP_BRANCH: begin slot_o.rs_rd = 1'b1; slot_o.rt_rd = 1'b1; slot_o.is_branch = 1'b1; end
            OP_JUMP:   slot_o.is_branch = 1'b1;
            OP_RSVD:   ;
            OP_NOP:    ;
        endcase
        // r0 is hardwired, so a write to it is never a real write
        slot_o.rd_we = wr && (slot_o.rd != 5'd0);
    end
endmodule

// File: rtl/decode_issue.sv
// Dual-slot decode and issue with split/bubble hazard handling.
// Optional DECODE_PERF_EN adds split and load-use bubble counters.
module decode_issue
    import decode_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    decode_issue_if.slave  bus
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]    perf_split_cnt,
    output logic [31:0]    perf_bubble_cnt
`endif
);
    dec_slot_t   s0, s1;
    state_t      state_q, state_d;
    logic        ld_hit, split_hit, hold, interlock;
    logic [1:0]  lanes;
    logic [1:0]  valid_q, valid_d;
    logic [63:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [9:0]  rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [1:0]  we_q, we_d, ld_q, ld_d, br_q, br_d;

    slot_decoder u_slot0 (.word_i(bus.bundle_in[63:32]), .slot_o(s0));
    slot_decoder u_slot1 (.word_i(bus.bundle_in[31:0]),  .slot_o(s1));

    // load results still in the output registers cannot be forwarded yet
    always_comb begin
        ld_hit = 1'b0;
        for (int l = 0; l < 2; l++) begin
            if (ld_q[l] && we_q[l]) begin
                if (state_q == FULL && reads_reg(s0, rd_q[l*5 +: 5])) ld_hit = 1'b1;
                if (reads_reg(s1, rd_q[l*5 +: 5])) ld_hit = 1'b1;
            end
        end
    end

    assign split_hit = (state_q == FULL) && s0.rd_we &&
                       (reads_reg(s1, s0.rd) || (s1.rd_we && s1.rd == s0.rd));

    always_comb begin
        state_d   = state_q;
        hold      = 1'b0;
        lanes     = 2'b00;
        interlock = 1'b0;
        if (bus.flush) begin
            state_d = FULL;
        end else if (bus.decode_stall) begin
            hold      = 1'b1;
            interlock = 1'b1;
        end else if (ld_hit) begin
            interlock = 1'b1;
        end else if (state_q == SECOND) begin
            lanes   = 2'b01;
            state_d = FULL;
        end else if (split_hit) begin
            lanes     = 2'b10;
            interlock = 1'b1;
            state_d   = SECOND;
        end else begin
            lanes = 2'b11;
        end
    end

    always_comb begin
        valid_d = lanes & {s0.valid, s1.valid};
        inst_d  = {valid_d[1] ? bus.bundle_in[63:32] : NOP_WORD,
                   valid_d[0] ? bus.bundle_in[31:0]  : NOP_WORD};
        pc_d    = bus.flush ? 32'd0 : bus.pc_in;
        rd_d    = {valid_d[1] ? s0.rd : 5'd0, valid_d[0] ? s1.rd : 5'd0};
        rs_d    = {valid_d[1] ? s0.rs : 5'd0, valid_d[0] ? s1.rs : 5'd0};
        rt_d    = {valid_d[1] ? s0.rt : 5'd0, valid_d[0] ? s1.rt : 5'd0};
        we_d    = valid_d & {s0.rd_we, s1.rd_we};
        ld_d    = valid_d & {s0.is_load, s1.is_load};
        br_d    = valid_d & {s0.is_branch, s1.is_branch};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= FULL;
            valid_q <= '0;
            inst_q  <= {NOP_WORD, NOP_WORD};
            pc_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            we_q    <= '0;
            ld_q    <= '0;
            br_q    <= '0;
        end else begin
            state_q <= state_d;
            if (!hold) begin
                valid_q <= valid_d;
                inst_q  <= inst_d;
                pc_q    <= pc_d;
                rd_q    <= rd_d;
                rs_q    <= rs_d;
                rt_q    <= rt_d;
                we_q    <= we_d;
                ld_q    <= ld_d;
                br_q    <= br_d;
            end
        end
    end

    assign bus.interlock     = interlock;
    assign bus.dec_valid     = valid_q;
    assign bus.dec_inst      = inst_q;
    assign bus.dec_pc        = pc_q;
    assign bus.dec_rd        = rd_q;
    assign bus.dec_rs        = rs_q;
    assign bus.dec_rt        = rt_q;
    assign bus.dec_we        = we_q;
    assign bus.dec_is_load   = ld_q;
    assign bus.dec_is_branch = br_q;

`ifdef DECODE_PERF_EN
    logic [31:0] split_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            split_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (state_q == FULL && state_d == SECOND)
                split_cnt_q <= split_cnt_q + 32'd1;
            if (ld_hit && !bus.flush && !bus.decode_stall)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign perf_split_cnt  = split_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif
endmodule
